// File: rtl/inv_pkg.sv
// Shared types and defaults for the vending-slot inventory manager.
package inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    DONE = 2'd2
  } rs_state_t;

  localparam int DEF_N_PROD     = 4;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_CAPACITY   = 15;
  localparam int DEF_MAX_SUPPLY = 15;
  localparam int DEF_INIT_STOCK = 0;
  localparam int DEF_LOW_THRESH = 2;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/restock_clip.sv
// Three-way minimum of requested quantity, remaining supply and stock headroom.
module restock_clip #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] qty,
  input  logic [CNT_W-1:0] supply,
  input  logic [CNT_W-1:0] headroom,
  output logic [CNT_W-1:0] applied,
  output logic             clipped
);

  logic [CNT_W:0] q, s, h, m1, m2;

  always_comb begin
    q  = {1'b0, qty};
    s  = {1'b0, supply};
    h  = {1'b0, headroom};
    m1 = (q < s) ? q : s;
    m2 = (m1 < h) ? m1 : h;
    applied = m2[CNT_W-1:0];
    clipped = (m2 < q);
  end

endmodule

// File: rtl/inventory_manager.sv
// Per-product stock/supply tracker: one-unit sales every cycle plus a
// three-state restock transaction that clips to supply and free capacity.
module inventory_manager
  import inv_pkg::*;
#(
  parameter int N_PROD     = DEF_N_PROD,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int MAX_SUPPLY = DEF_MAX_SUPPLY,
  parameter int INIT_STOCK = DEF_INIT_STOCK,
  parameter int LOW_THRESH = DEF_LOW_THRESH,
  localparam int ID_W      = id_width(N_PROD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restock_valid,
  output logic                    restock_ready,
  input  logic [ID_W-1:0]         restock_id,
  input  logic [CNT_W-1:0]        restock_qty,
  output logic                    restock_done,
  output logic [CNT_W-1:0]        restock_applied,
  output logic                    restock_clipped,
  input  logic                    sale_valid,
  input  logic [ID_W-1:0]         sale_id,
  output logic                    sale_ok,
  output logic                    sale_fail,
  input  logic                    refill,
  output logic [N_PROD*CNT_W-1:0] stock_flat,
  output logic [N_PROD*CNT_W-1:0] supply_flat,
  output logic [N_PROD*CNT_W-1:0] headroom_flat,
  output logic [N_PROD-1:0]       low_flag
);

  if (N_PROD < 2 || CAPACITY >= 2**CNT_W || MAX_SUPPLY >= 2**CNT_W ||
      INIT_STOCK > CAPACITY) begin : g_bad_param
    $fatal(1, "inventory_manager: parameter out of range");
  end

  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] MAXS_C = CNT_W'(MAX_SUPPLY);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_STOCK);

  rs_state_t        state, state_nxt;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] qty_q, applied_q;
  logic             clipped_q;
  logic [CNT_W-1:0] stock [N_PROD];
  logic [CNT_W-1:0] supply [N_PROD];
  logic [CNT_W-1:0] stock_nxt [N_PROD];
  logic             id_ok, sale_id_ok, sale_hit, accept;
  logic [CNT_W-1:0] sale_stock, sel_stock, sel_supply, sel_after, sel_headroom;
  logic [CNT_W-1:0] applied;
  logic             clipped;

  assign id_ok      = ({1'b0, restock_id} < (ID_W+1)'(N_PROD));
  assign sale_id_ok = ({1'b0, sale_id} < (ID_W+1)'(N_PROD));
  assign accept     = (state == IDLE) && restock_valid && id_ok;

  always_comb begin
    sale_stock = '0;
    sel_stock  = '0;
    sel_supply = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      if (sale_id == ID_W'(i)) sale_stock = stock[i];
      if (id_q == ID_W'(i)) begin
        sel_stock  = stock[i];
        sel_supply = supply[i];
      end
    end
    sale_hit = sale_valid && sale_id_ok && (sale_stock != '0);
    // Headroom must see a same-cycle sale on the restocked product.
    sel_after    = sel_stock - CNT_W'(sale_hit && (sale_id == id_q));
    sel_headroom = CAP_C - sel_after;
  end

  restock_clip #(.CNT_W(CNT_W)) u_clip (
    .qty      (qty_q),
    .supply   (sel_supply),
    .headroom (sel_headroom),
    .applied  (applied),
    .clipped  (clipped)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_PROD; i++) begin
      stock_nxt[i] = stock[i];
      if (sale_hit && (sale_id == ID_W'(i))) stock_nxt[i] = stock_nxt[i] - CNT_W'(1);
      if ((state == CLIP) && (id_q == ID_W'(i))) stock_nxt[i] = stock_nxt[i] + applied;
    end
  end

  always_comb begin
    state_nxt     = state;
    restock_ready = 1'b0;
    case (state)
      IDLE: begin
        restock_ready = 1'b1;
        if (restock_valid && id_ok) state_nxt = CLIP;
      end
      CLIP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      qty_q     <= '0;
      applied_q <= '0;
      clipped_q <= 1'b0;
      sale_ok   <= 1'b0;
      sale_fail <= 1'b0;
      for (int unsigned i = 0; i < N_PROD; i++) begin
        stock[i]    <= INIT_C;
        supply[i]   <= MAXS_C;
        low_flag[i] <= (INIT_STOCK <= LOW_THRESH);
      end
    end else begin
      if (accept) begin
        id_q  <= restock_id;
        qty_q <= restock_qty;
      end
      if (state == CLIP) begin
        applied_q <= applied;
        clipped_q <= clipped;
      end
      sale_ok   <= sale_hit;
      sale_fail <= sale_valid && !sale_hit;
      for (int unsigned i = 0; i < N_PROD; i++) begin
        stock[i]    <= stock_nxt[i];
        low_flag[i] <= (int'(stock_nxt[i]) <= LOW_THRESH);
        if (refill)
          supply[i] <= MAXS_C;
        else if ((state == CLIP) && (id_q == ID_W'(i)))
          supply[i] <= supply[i] - applied;
      end
    end
  end

  assign restock_done    = (state == DONE);
  assign restock_applied = restock_done ? applied_q : '0;
  assign restock_clipped = restock_done && clipped_q;

  always_comb begin
    stock_flat    = '0;
    supply_flat   = '0;
    headroom_flat = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      stock_flat[i*CNT_W +: CNT_W]    = stock[i];
      supply_flat[i*CNT_W +: CNT_W]   = supply[i];
      headroom_flat[i*CNT_W +: CNT_W] = CAP_C - stock[i];
    end
  end

endmodule

// File: tb/tb_inventory_manager.sv
// Directed plus randomized checks of inventory_manager against an arithmetic stock/supply model.
module tb_inventory_manager;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int CAP  = 15;
  localparam int MAXS = 15;
  localparam int LOW  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         restock_valid = 1'b0;
  logic         restock_ready;
  logic [1:0]   restock_id = '0;
  logic [W-1:0] restock_qty = '0;
  logic         restock_done;
  logic [W-1:0] restock_applied;
  logic         restock_clipped;
  logic         sale_valid = 1'b0;
  logic [1:0]   sale_id = '0;
  logic         sale_ok, sale_fail;
  logic         refill = 1'b0;
  logic [N*W-1:0] stock_flat, supply_flat, headroom_flat;
  logic [N-1:0]   low_flag;

  int n_assert = 0;
  int n_fail   = 0;
  int stock_m  [N];
  int supply_m [N];

  inventory_manager #(
    .N_PROD(N), .CNT_W(W), .CAPACITY(CAP), .MAX_SUPPLY(MAXS),
    .INIT_STOCK(0), .LOW_THRESH(LOW)
  ) dut (
    .clk(clk), .rst(rst),
    .restock_valid(restock_valid), .restock_ready(restock_ready),
    .restock_id(restock_id), .restock_qty(restock_qty),
    .restock_done(restock_done), .restock_applied(restock_applied),
    .restock_clipped(restock_clipped),
    .sale_valid(sale_valid), .sale_id(sale_id),
    .sale_ok(sale_ok), .sale_fail(sale_fail),
    .refill(refill),
    .stock_flat(stock_flat), .supply_flat(supply_flat),
    .headroom_flat(headroom_flat), .low_flag(low_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      stock_m[i]  = 0;
      supply_m[i] = MAXS;
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s stock%0d", ctx, i), stock_flat[i*W +: W], stock_m[i]);
      chk($sformatf("%s supply%0d", ctx, i), supply_flat[i*W +: W], supply_m[i]);
      chk($sformatf("%s headroom%0d", ctx, i), headroom_flat[i*W +: W], CAP - stock_m[i]);
      chk($sformatf("%s low%0d", ctx, i), low_flag[i], (stock_m[i] <= LOW) ? 1 : 0);
    end
  endtask

  task automatic do_sale(input int id);
    int exp_ok;
    exp_ok     = (stock_m[id] > 0) ? 1 : 0;
    sale_valid = 1'b1;
    sale_id    = 2'(id);
    step();
    sale_valid = 1'b0;
    if (exp_ok == 1) stock_m[id]--;
    chk("sale_ok", sale_ok, exp_ok);
    chk("sale_fail", sale_fail, 1 - exp_ok);
    check_all("after sale");
    step();
    chk("sale_ok pulse width", sale_ok, 0);
    chk("sale_fail pulse width", sale_fail, 0);
  endtask

  task automatic do_restock(input int id, input int qty, input int sale_en,
                            input int sid, input int rf);
    int after, ap, clip, s_ok;
    chk("ready idle", restock_ready, 1);
    restock_valid = 1'b1;
    restock_id    = 2'(id);
    restock_qty   = W'(qty);
    step();
    restock_valid = 1'b0;
    chk("ready clip", restock_ready, 0);
    chk("done early", restock_done, 0);
    check_all("accept");
    sale_valid = sale_en[0];
    sale_id    = 2'(sid);
    refill     = rf[0];
    s_ok = (sale_en != 0 && stock_m[sid] > 0) ? 1 : 0;
    if (s_ok == 1) stock_m[sid]--;
    after = stock_m[id];
    ap = qty;
    if (supply_m[id] < ap) ap = supply_m[id];
    if (CAP - after < ap) ap = CAP - after;
    clip = (ap < qty) ? 1 : 0;
    stock_m[id]  = after + ap;
    supply_m[id] = supply_m[id] - ap;
    if (rf != 0) for (int i = 0; i < N; i++) supply_m[i] = MAXS;
    step();
    sale_valid = 1'b0;
    refill     = 1'b0;
    chk("done", restock_done, 1);
    chk("applied", restock_applied, ap);
    chk("clipped", restock_clipped, clip);
    if (sale_en != 0) begin
      chk("clip sale_ok", sale_ok, s_ok);
      chk("clip sale_fail", sale_fail, 1 - s_ok);
    end
    check_all("restock");
    step();
    chk("done pulse width", restock_done, 0);
    chk("ready back", restock_ready, 1);
  endtask

  task automatic do_refill();
    refill = 1'b1;
    step();
    refill = 1'b0;
    for (int i = 0; i < N; i++) supply_m[i] = MAXS;
    check_all("refill");
  endtask

  initial begin
    model_reset();
    // 1. reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", restock_ready, 1);
    chk("rst done", restock_done, 0);
    chk("rst applied", restock_applied, 0);
    chk("rst clipped", restock_clipped, 0);
    chk("rst sale_ok", sale_ok, 0);
    chk("rst sale_fail", sale_fail, 0);
    chk("rst low_flag", low_flag, 4'b1111);
    check_all("reset");
    rst = 1'b0;
    step();
    check_all("post reset");

    // 2./3. restock, clipping by supply and capacity, refill
    do_restock(1, 9, 0, 0, 0);
    chk("stock1 is 9", stock_flat[4 +: 4], 9);
    do_restock(1, 9, 0, 0, 0);
    chk("supply1 is 0", supply_flat[4 +: 4], 0);
    do_restock(1, 3, 0, 0, 0);
    do_refill();

    // 4. sales at full and empty slots
    do_sale(1);
    do_sale(2);

    // 5. sale on the restocked product during CLIP
    do_restock(0, 5, 0, 0, 0);
    do_refill();
    do_restock(0, 15, 1, 0, 0);
    chk("stock0 is 15", stock_flat[0 +: 4], 15);
    chk("supply0 is 4", supply_flat[0 +: 4], 4);

    // refill colliding with a CLIP writeback
    do_restock(2, 7, 0, 0, 1);

    // 6. reset during CLIP aborts the transaction
    restock_valid = 1'b1;
    restock_id    = 2'd0;
    restock_qty   = 4'd5;
    step();
    restock_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort ready", restock_ready, 1);
    chk("abort done", restock_done, 0);
    check_all("abort");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no done after abort", restock_done, 0);
    end
    check_all("after abort");
    do_restock(3, 2, 0, 0, 0);
    chk("low3 set", low_flag[3], 1);

    // randomized mix
    for (int k = 0; k < 60; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3)
        do_sale(int'($urandom_range(0, N - 1)));
      else if (op <= 8)
        do_restock(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                   ($urandom_range(0, 4) == 0) ? 1 : 0);
      else
        do_refill();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inventory_manager.md
Name: inventory_manager

Overview:
Parametrised stock and replenishment tracker for N_PROD vending slots. Replaces the fixed 4-product manager with per-product stock and supply-budget registers, a valid/ready restock transaction with clipping, single-cycle sale handling, a low-stock flag and a global supply refill. Sits between the keypad/selection front end and the sale/display logic.

Parameters:
N_PROD, 4, number of products (>=2)
CNT_W, 4, width of stock, quantity and supply counters
CAPACITY, 15, maximum stock per product (< 2**CNT_W)
MAX_SUPPLY, 15, replenishment budget per product after reset or refill (< 2**CNT_W)
INIT_STOCK, 0, stock value after reset (<= CAPACITY)
LOW_THRESH, 2, low-stock flag threshold

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
restock_valid  in  1  restock request
restock_ready  out  1  block can accept a restock request
restock_id  in  ID_W  product index, ID_W = max(1, clog2(N_PROD))
restock_qty  in  CNT_W  requested units
restock_done  out  1  one-cycle pulse when the restock completes
restock_applied  out  CNT_W  units actually added; valid with restock_done
restock_clipped  out  1  applied < requested; valid with restock_done
sale_valid  in  1  one-unit sale request
sale_id  in  ID_W  product index for the sale
sale_ok  out  1  one-cycle pulse: sale accepted
sale_fail  out  1  one-cycle pulse: sale rejected
refill  in  1  one-cycle pulse: reload every supply budget to MAX_SUPPLY
stock_flat  out  N_PROD*CNT_W  current stock; product i occupies [i*CNT_W +: CNT_W]
supply_flat  out  N_PROD*CNT_W  remaining replenishment budget per product
headroom_flat  out  N_PROD*CNT_W  CAPACITY - stock per product (combinational)
low_flag  out  N_PROD  registered: stock <= LOW_THRESH

Behaviour:
- Reset, asynchronous and immediate:
  - stock = INIT_STOCK and supply = MAX_SUPPLY for every product.
  - low_flag reflects INIT_STOCK.
  - FSM goes to IDLE. restock_ready = 1.
  - restock_done, restock_applied, restock_clipped, sale_ok and sale_fail are all 0.
- Restock FSM has three states: IDLE, CLIP, DONE.
  - IDLE: restock_ready = 1. On restock_valid, register id and qty, then go to CLIP. A request with id >= N_PROD is ignored and the FSM stays in IDLE.
  - CLIP: restock_ready = 0.
    - applied = min(qty, supply[id], CAPACITY - stock_after_sale[id]).
    - stock_after_sale is stock minus 1 if a sale on the same id is accepted in this cycle.
    - At the end of the cycle: stock[id] = stock_after_sale + applied; supply[id] = supply[id] - applied. Then go to DONE.
  - DONE: restock_done = 1 for one cycle, with restock_applied and restock_clipped registered. Go to IDLE.
  - Result: accept-to-update latency is 1 cycle, and restock_done asserts 2 cycles after accept. Back-to-back restocks run every 3 cycles.
- Restock arithmetic:
  - All comparisons are done at CNT_W+1 bits. No wrap-around is possible.
  - qty = 0 gives applied = 0 and clipped = 0.
  - If supply = 0 or headroom = 0, applied = 0 and clipped = (qty != 0).
- Sale:
  - Evaluated every cycle in any FSM state, single cycle.
  - If sale_valid, sale_id < N_PROD and stock[sale_id] > 0: decrement stock at the edge and pulse sale_ok in the next cycle.
  - Otherwise, when sale_valid is high: stock is unchanged and sale_fail pulses in the next cycle.
  - Sales never touch supply.
- refill: all supply registers are set to MAX_SUPPLY at the edge. If a CLIP writeback happens in the same cycle, refill wins for supply; the stock update still applies.
- low_flag[i] is registered from the next-state stock, so it updates on the same edge as stock.
- Reset during CLIP or DONE: the transaction is aborted, no restock_done pulse is produced, and all state returns to reset values.
- Elaboration checks: CAPACITY, MAX_SUPPLY and INIT_STOCK must fit in CNT_W bits; otherwise a fatal error.

Decomposition:
- Shared package/header `inv_pkg`:
  - FSM state encoding (IDLE = 0, CLIP = 1, DONE = 2).
  - ID_W derivation function.
  - Default parameter constants.
- One combinational sub-module, `restock_clip`:
  - Inputs: qty, supply, headroom.
  - Outputs: applied (3-way min) and clipped.
  - Instantiated once in CLIP.

Test Plan (all defaults: N_PROD=4, CNT_W=4, CAPACITY=15, MAX_SUPPLY=15, INIT_STOCK=0, LOW_THRESH=2):
1. Reset: pulse rst -> all stock = 0, all supply = 15, low_flag = 4'b1111, restock_ready = 1, no output pulses.
2. Restock: id 1, qty 9 -> stock1 = 9 one edge after accept; restock_done two cycles after accept with applied = 9 and clipped = 0; supply1 = 6; low_flag[1] = 0.
3. Clipping: restock id 1 qty 9 again -> applied = 6, clipped = 1, stock1 = 15, supply1 = 0. Then restock id 1 qty 3 -> applied = 0, clipped = 1, nothing changes. Then refill -> supply1 = 15.
4. Sales: sale id 1 at stock 15 -> sale_ok, stock1 = 14. Sale id 2 at stock 0 -> sale_fail, stock2 stays 0.
5. Simultaneous sale and restock: stock0 = 5, restock id 0 qty 15, sale id 0 asserted in the CLIP cycle -> sale_ok, applied = 11, clipped = 1, stock0 = 15, supply0 = 4.
6. Reset mid-transaction: assert rst during CLIP -> FSM back to IDLE, no restock_done, stock = 0, supply = 15. Then a restock id 3 qty 2 completes normally -> stock3 = 2, low_flag[3] = 1.
